alu_mul_seq: RTL
================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter EARLY_EXIT, default 1; 1 = end iteration once remaining multiplier bits are zero, 0 = always 32 iterations.
REQ-002 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port Start, input, 1, request to multiply OpA by OpB.
REQ-005 SHALL have ports OpA and OpB, input, 32 each, multiplicand and multiplier (unsigned).
REQ-006 SHALL have port Busy, output, 1, high while an operation is in progress.
REQ-007 SHALL have port Done, output, 1, one-cycle pulse marking Result valid.
REQ-008 SHALL have port Result, output, 32, low 32 bits of OpA*OpB.
REQ-009 SHALL have port AluReq, output, 1, high while this block owns the shared ALU.
REQ-010 SHALL have ports AluCtl, AluShamt, AluA and AluB, outputs, 3/5/32/32, driving the shared ALU Ctl, shamt, DataA and DataB.
REQ-011 SHALL have port AluOut, input, 32, shared ALU DataOut.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 IDLE with Start=1 SHALL latch mcand=OpA, mplier=OpB, acc=0 and cnt=0, then enter RUN; Start is accepted only in IDLE.
REQ-014 Each RUN cycle SHALL do the following:
- if mplier[0]=1, acc <= AluOut;
- mcand <= mcand<<1 (logical);
- mplier <= mplier>>1 (logical);
- cnt <= cnt+1.
REQ-015 In RUN, the ALU drive SHALL be AluCtl=3'b010 (add), AluA=acc, AluB=mcand, AluShamt=0 and AluReq=1.
REQ-016 Outside RUN, the ALU drive SHALL be AluCtl=3'b000, AluA=0, AluB=0, AluShamt=0 and AluReq=0.
REQ-017 RUN SHALL exit to DONE after the iteration with cnt=31, or, if EARLY_EXIT=1, after the first iteration whose shifted mplier is zero.
REQ-018 With EARLY_EXIT=0 and Start sampled in cycle N, Busy SHALL be high in cycles N+1..N+32 and Done high in cycle N+33 only.
REQ-019 With EARLY_EXIT=1, the number of RUN cycles SHALL be max(1, msb_index(OpB)+1).
REQ-020 DONE SHALL last exactly one cycle with Done=1, Busy=0, then return to IDLE; Start during DONE SHALL be ignored.
REQ-021 Result SHALL update with acc on entry to DONE and hold until the next DONE.
REQ-022 Arithmetic SHALL be modulo 2^32; overflow is silently discarded and no flag is raised.
REQ-023 Start and operand changes while Busy=1 SHALL be ignored and SHALL NOT disturb the operation in flight.

Reset
REQ-024 rst=1 SHALL immediately force IDLE and set Busy=0, Done=0, Result=0, AluReq=0, all Alu* outputs to 0, and acc, mcand, mplier and cnt to 0.
REQ-025 Reset during RUN SHALL abort the operation with no Done pulse; the first Start after reset release SHALL be accepted normally.

Structure
REQ-026 The ALU control codes (ADD=010, SUB=110, OR=001, SLT=011, SRL=111) and the FSM state encodings SHALL live in the shared ALU definitions package, not locally.
REQ-027 No sub-module SHALL be instantiated; the ALU remains external and shared, and ownership arbitration is performed outside using AluReq.
REQ-028 The implementation SHALL use a 5-bit cnt, 32-bit acc, mcand and mplier registers, and a 2-bit state register.

Verification
REQ-029 Scenario: EARLY_EXIT=0, OpA=3, OpB=5, Start in cycle N -> Busy in N+1..N+32, Done pulse in N+33, Result=15.
REQ-030 Scenario: OpA=0xFFFFFFFF, OpB=0xFFFFFFFF -> Result=0x00000001 (wrap), a single Done pulse.
REQ-031 Scenario: EARLY_EXIT=1, OpA=7, OpB=0 -> one RUN cycle, Done in N+2, Result=0; OpB=5 -> Done in N+4, Result=35.
REQ-032 Scenario: Start re-asserted with new operands during Busy and during DONE -> ignored, Result equals the first product, exactly one Done pulse.
REQ-033 Scenario: rst asserted in cycle N+10 of a run -> all outputs 0 immediately, no Done pulse; a new Start with 0x00010000 x 0x00010000 -> Result=0.
REQ-034 Scenario: check throughout all runs -> AluCtl=010 and AluReq=1 exactly in the Busy cycles, otherwise AluCtl=000 and AluReq=0.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq_pkg
//  Description : Shared ALU definitions: control codes for the external ALU,
//                multiplier sequencer state encodings and an iteration helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_mul_seq_pkg;

    // Control codes understood by the shared ALU.
    // ALU_IDLE is the quiescent code driven while nobody owns the ALU.
    typedef enum logic [2:0] {
        ALU_IDLE = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_SUB  = 3'b110,
        ALU_SRL  = 3'b111
    } alu_ctl_e;

    // Multiplier sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    localparam int MUL_WIDTH = 32;
    localparam int CNT_WIDTH = 5;

    // True when the iteration currently executing is the final one: either all
    // 32 multiplier bits have been consumed, or (early exit) nothing but zeros
    // remain in the multiplier after this shift.
    function automatic logic is_last_iter(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [MUL_WIDTH-1:0] mplier_next,
        input logic                 early_exit
    );
        return (cnt == {CNT_WIDTH{1'b1}}) || (early_exit && (mplier_next == '0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Sequential shift-and-add 32x32 unsigned multiplier (low 32
//                result bits). The add of each iteration is borrowed from an
//                external shared ALU, requested through AluReq.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int EARLY_EXIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic        AluReq,
    output logic [2:0]  AluCtl,
    output logic [4:0]  AluShamt,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    input  logic [31:0] AluOut
);

    mul_state_e              r_state;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [MUL_WIDTH-1:0]    r_acc;
    logic [MUL_WIDTH-1:0]    r_mcand;
    logic [MUL_WIDTH-1:0]    r_mplier;
    logic [MUL_WIDTH-1:0]    r_result;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_alu_req;
    alu_ctl_e                r_alu_ctl;

    logic                    w_early_exit;
    logic [MUL_WIDTH-1:0]    w_acc_next;
    logic [MUL_WIDTH-1:0]    w_mcand_next;
    logic [MUL_WIDTH-1:0]    w_mplier_next;
    logic                    w_last;

    // Early termination is a build-time choice; tie the enable off accordingly.
    generate
        if (EARLY_EXIT != 0) begin : g_early_exit
            assign w_early_exit = 1'b1;
        end else begin : g_full_iter
            assign w_early_exit = 1'b0;
        end
    endgenerate

    // One shift-and-add step: the ALU returns acc + mcand, kept only when the
    // current multiplier bit is set. Shifts are logical; overflow just wraps.
    assign w_acc_next    = r_mplier[0] ? AluOut : r_acc;
    assign w_mcand_next  = r_mcand << 1;
    assign w_mplier_next = r_mplier >> 1;
    assign w_last        = is_last_iter(r_cnt, w_mplier_next, w_early_exit);

    // Sequencer: operand capture, iteration, result latch and ALU ownership flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_alu_req <= 1'b0;
            r_alu_ctl <= ALU_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_mcand   <= OpA;
                        r_mplier  <= OpB;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_alu_req <= 1'b1;
                        r_alu_ctl <= ALU_ADD;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= w_mcand_next;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Capture the accumulator including this final step.
                        r_result  <= w_acc_next;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_alu_req <= 1'b0;
                        r_alu_ctl <= ALU_IDLE;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Start is deliberately not looked at here.
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_alu_req <= 1'b0;
                    r_alu_ctl <= ALU_IDLE;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // The ALU operand buses are driven only while this block owns the ALU,
    // so an idle or reset sequencer presents all zeros to the arbiter.
    assign AluA     = r_alu_req ? r_acc   : '0;
    assign AluB     = r_alu_req ? r_mcand : '0;
    assign AluShamt = 5'd0;
    assign AluCtl   = r_alu_ctl;
    assign AluReq   = r_alu_req;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Result   = r_result;

endmodule
`default_nettype wire
